// File: rtl/stk_pkg.sv
// Shared types and constants for the stack line-store bank and its scan checker.
package stk_pkg;

   localparam int C_BANK_LINES_N   = 300;
   localparam int C_LINE_ID_W      = $clog2(C_BANK_LINES_N);
   localparam int C_LINE_W         = 128;
   localparam int C_SCAN_ERR_CNT_W = 8;

   typedef logic [C_LINE_ID_W-1:0] line_id_t;

   // One-hot scan sequencer states.
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_ISSUE = 4'b0010,
      S_DRAIN = 4'b0100,
      S_DONE  = 4'b1000
   } scan_state_e;

endpackage

// File: rtl/stk_pipe_al_scan_rsp.sv
// Response tracker for the scan checker: delays read-valid and read-address by RD_LAT
// cycles so the head lines up with the bank's returned data. Flush drops everything in flight.
module stk_pipe_al_scan_rsp
   import stk_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic     clk,
   input  logic     arst_n,
   input  logic     flush_i,
   input  logic     vld_i,
   input  line_id_t addr_i,
   output logic     head_vld_o,
   output line_id_t head_addr_o,
   output logic     pend_o
);

   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] vld_d;
   line_id_t          addr_q [RD_LAT];
   line_id_t          addr_d [RD_LAT];

   for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_entry
         assign vld_d[gi]  = vld_i & ~flush_i;
         assign addr_d[gi] = addr_i;
      end else begin : g_chain
         assign vld_d[gi]  = vld_q[gi-1] & ~flush_i;
         assign addr_d[gi] = addr_q[gi-1];
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   assign head_vld_o  = vld_q[RD_LAT-1];
   assign head_addr_o = addr_q[RD_LAT-1];

   // Reads still in flight behind the head; the sweep is finished once this and the head clear.
   if (RD_LAT > 1) begin : g_pend
      assign pend_o = |vld_q[RD_LAT-2:0];
   end else begin : g_no_pend
      assign pend_o = 1'b0;
   end

endmodule

// File: rtl/stk_pipe_al_scan.sv
// Read-side sweep checker for the stack line-store bank: reads every line once, compares it
// against EXP_DATA and reports pass/fail, a saturating error count and the first failing line.
module stk_pipe_al_scan
   import stk_pkg::*;
#(
   parameter int                  LINES_N   = C_BANK_LINES_N,
   parameter int                  RD_LAT    = 1,
   parameter logic [C_LINE_W-1:0] EXP_DATA  = '0,
   parameter int                  ERR_CNT_W = C_SCAN_ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 i_start,
   output logic                 o_rd_en_r,
   output line_id_t             o_rd_addr_r,
   input  logic [C_LINE_W-1:0]  i_rd_data,
   output logic                 o_busy_r,
   output logic                 o_done_r,
   output logic                 o_pass_r,
   output logic [ERR_CNT_W-1:0] o_err_cnt_r,
   output line_id_t             o_err_addr_r
);

   localparam line_id_t               LAST_ADDR = line_id_t'(LINES_N - 1);
   localparam line_id_t               ADDR_ONE  = line_id_t'(1);
   localparam logic [ERR_CNT_W-1:0]   CNT_ONE   = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0]   CNT_MAX   = '1;

   scan_state_e            state_q, state_d;
   line_id_t               addr_q, addr_d;
   logic                   rd_en_q, rd_en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   line_id_t               err_addr_q, err_addr_d;

   logic                   flush;
   logic                   rsp_vld;
   line_id_t               rsp_addr;
   logic                   rsp_pend;
   logic                   mismatch;

   stk_pipe_al_scan_rsp #(
      .RD_LAT (RD_LAT)
   ) u_rsp (
      .clk         (clk),
      .arst_n      (arst_n),
      .flush_i     (flush),
      .vld_i       (rd_en_q),
      .addr_i      (addr_q),
      .head_vld_o  (rsp_vld),
      .head_addr_o (rsp_addr),
      .pend_o      (rsp_pend)
   );

   assign mismatch = rsp_vld && (state_q == S_ISSUE || state_q == S_DRAIN) &&
                     (i_rd_data != EXP_DATA);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_en_d    = 1'b0;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      flush      = 1'b0;

      if (mismatch) begin
         if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
         end
         if (err_cnt_q == '0) begin
            err_addr_d = rsp_addr;
         end
      end

      unique case (state_q)
         S_IDLE: begin
         end
         S_ISSUE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               rd_en_d = 1'b1;
            end
         end
         S_DRAIN: begin
            // The head compare happening this cycle is the last one once nothing trails it.
            if (!rsp_pend && !rd_en_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A start pulse always wins, including over the final compare of a sweep.
      if (i_start) begin
         state_d    = S_ISSUE;
         addr_d     = '0;
         rd_en_d    = 1'b1;
         err_cnt_d  = '0;
         err_addr_d = '0;
         flush      = 1'b1;
      end

      busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign o_rd_en_r    = rd_en_q;
   assign o_rd_addr_r  = addr_q;
   assign o_busy_r     = busy_q;
   assign o_done_r     = done_q;
   assign o_pass_r     = pass_q;
   assign o_err_cnt_r  = err_cnt_q;
   assign o_err_addr_r = err_addr_q;

endmodule

// File: tb/tb_stk_pipe_al_scan.sv
// Bench for the bank scan checker: two instances (read latency 1 and 3) share stimulus;
// a bank model answers reads, a scoreboard holds expected sweep results per instance.
module tb_stk_pipe_al_scan;
   import stk_pkg::*;

   localparam int LINES_N = C_BANK_LINES_N;
   localparam int NL      = 2;

   typedef struct {
      logic        e_pass;
      logic [7:0]  e_cnt;
      line_id_t    e_addr;
      int unsigned e_cyc;
   } exp_t;

   typedef struct {
      int unsigned due;
      line_id_t    addr;
   } rd_t;

   logic          clk    = 1'b0;
   logic          arst_n = 1'b1;
   logic          start  = 1'b0;
   logic          rd_en    [NL];
   line_id_t      rd_addr  [NL];
   logic [127:0]  rd_data  [NL];
   logic          busy     [NL];
   logic          done     [NL];
   logic          pass     [NL];
   logic [7:0]    err_cnt  [NL];
   line_id_t      err_addr [NL];

   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   bit            corrupt [LINES_N];
   exp_t          exp_q [NL][$];
   int unsigned   t_start = 0;
   int unsigned   t0 = 0;
   int            k_rand = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int lane, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s lane%0d cyc=%0d: got %0h expected %0h", name, lane, cyc, act, exp);
   endtask

   function automatic int lat_of(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   // Expected sweep outcome straight from the corruption map.
   function automatic exp_t model(input int l, input int unsigned t);
      exp_t e;
      int   n = 0;
      int   first = -1;
      for (int a = 0; a < LINES_N; a++) begin
         if (corrupt[a]) begin
            n++;
            if (first < 0) first = a;
         end
      end
      e.e_pass = (n == 0);
      e.e_cnt  = (n > 255) ? 8'hFF : 8'(n);
      e.e_addr = (first < 0) ? '0 : line_id_t'(first);
      e.e_cyc  = t + LINES_N + lat_of(l) + 1;
      return e;
   endfunction

   task automatic clear_corrupt();
      for (int a = 0; a < LINES_N; a++) corrupt[a] = 1'b0;
   endtask

   task automatic start_sweep(input bit replace);
      @(posedge clk); #1;
      start   = 1'b1;
      t_start = cyc;
      for (int l = 0; l < NL; l++) begin
         if (replace && exp_q[l].size() > 0) void'(exp_q[l].pop_back());
         exp_q[l].push_back(model(l, cyc));
      end
      $display("start sweep: cycle %0d restart=%0d", cyc, replace);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i = 0;
      while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && i < LINES_N + 20) begin
         @(negedge clk); #1;
         i++;
      end
      chk({name, "_timeout"}, 0, 128'(exp_q[0].size() + exp_q[1].size()), 128'h0);
      exp_q[0].delete();
      exp_q[1].delete();
   endtask

   task automatic run(input string name);
      start_sweep(1'b0);
      wait_done(name);
   endtask

   task automatic wait_addr(input int a);
      int i = 0;
      while (!(rd_en[0] === 1'b1 && rd_addr[0] == line_id_t'(a)) && i < LINES_N) begin
         @(negedge clk);
         i++;
      end
      chk("addr_reached", 0, 128'(rd_addr[0]), 128'(a));
   endtask

   for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      localparam int LAT = (gi == 0) ? 1 : 3;
      rd_t      rdq [$];
      rd_t      push_e;
      exp_t     pop_e;
      int       reads_left = 0;
      line_id_t next_addr = '0;
      bit       start_pend = 1'b0;
      logic     done_prev = 1'b0;

      stk_pipe_al_scan #(
         .LINES_N (LINES_N),
         .RD_LAT  (LAT)
      ) u_dut (
         .clk          (clk),
         .arst_n       (arst_n),
         .i_start      (start),
         .o_rd_en_r    (rd_en[gi]),
         .o_rd_addr_r  (rd_addr[gi]),
         .i_rd_data    (rd_data[gi]),
         .o_busy_r     (busy[gi]),
         .o_done_r     (done[gi]),
         .o_pass_r     (pass[gi]),
         .o_err_cnt_r  (err_cnt[gi]),
         .o_err_addr_r (err_addr[gi])
      );

      // Bank: a read seen in cycle c returns its line during cycle c+LAT, garbage otherwise.
      always @(negedge clk) begin
         if (arst_n && rd_en[gi] === 1'b1) begin
            push_e.due  = cyc + LAT;
            push_e.addr = rd_addr[gi];
            rdq.push_back(push_e);
         end
      end

      always @(posedge clk) begin
         #1;
         while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            rd_data[gi] = corrupt[rdq[0].addr] ? 128'h1 : 128'h0;
            void'(rdq.pop_front());
         end else begin
            rd_data[gi] = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
      end

      // Monitor: read sequence, invariants and scoreboard pop on each new done.
      always @(negedge clk) begin
         if (!arst_n) begin
            reads_left = 0;
            start_pend = 1'b0;
            done_prev  = 1'b0;
            chk("reset_outputs", gi,
                128'({rd_en[gi], busy[gi], done[gi], pass[gi], err_cnt[gi], err_addr[gi]}), 128'h0);
         end else begin
            if (start_pend) begin
               reads_left = LINES_N;
               next_addr  = '0;
            end
            start_pend = start;
            chk("rd_en", gi, 128'(rd_en[gi]), 128'(reads_left > 0));
            if (reads_left > 0) begin
               chk("rd_addr", gi, 128'(rd_addr[gi]), 128'(next_addr));
               reads_left--;
               next_addr = next_addr + line_id_t'(1);
            end
            chk("busy_done_excl", gi, 128'(busy[gi] & done[gi]), 128'h0);
            chk("pass_needs_done", gi, 128'(pass[gi] & ~done[gi]), 128'h0);
            if (done[gi] === 1'b1 && !done_prev) begin
               $display("lane%0d done: cycle %0d pass=%0d err_cnt=%0d err_addr=%0d",
                        gi, cyc, pass[gi], err_cnt[gi], err_addr[gi]);
               if (exp_q[gi].size() == 0) begin
                  chk("done_unrequested", gi, 128'(done[gi]), 128'h0);
               end else begin
                  pop_e = exp_q[gi].pop_front();
                  chk("pass", gi, 128'(pass[gi]), 128'(pop_e.e_pass));
                  chk("err_cnt", gi, 128'(err_cnt[gi]), 128'(pop_e.e_cnt));
                  chk("err_addr", gi, 128'(err_addr[gi]), 128'(pop_e.e_addr));
                  chk("done_cycle", gi, 128'(cyc), 128'(pop_e.e_cyc));
               end
            end
            done_prev = done[gi];
         end
      end
   end

   initial begin
      clear_corrupt();
      #1 arst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 arst_n = 1'b1;

      run("clean");

      corrupt[5] = 1'b1;
      corrupt[9] = 1'b1;
      run("two_bad");

      for (int a = 0; a < LINES_N; a++) corrupt[a] = 1'b1;
      run("all_bad");

      for (int r = 0; r < 4; r++) begin
         clear_corrupt();
         k_rand = $urandom_range(0, 5);
         for (int k = 0; k < k_rand; k++) corrupt[$urandom_range(0, LINES_N - 1)] = 1'b1;
         run("random");
      end

      // Restart mid-sweep.
      clear_corrupt();
      corrupt[3] = 1'b1;
      start_sweep(1'b0);
      wait_addr(10);
      start_sweep(1'b1);
      wait_done("restart_mid");

      // Restart on the very edge that would complete the latency-1 sweep.
      clear_corrupt();
      corrupt[LINES_N-1] = 1'b1;
      start_sweep(1'b0);
      t0 = t_start;
      while (cyc < t0 + LINES_N) begin
         @(posedge clk); #1;
      end
      start_sweep(1'b1);
      wait_done("restart_last");

      // Asynchronous reset mid-sweep, then a quiet gap, then a clean sweep.
      clear_corrupt();
      corrupt[2] = 1'b1;
      start_sweep(1'b0);
      wait_addr(20);
      @(posedge clk); #1;
      arst_n = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      repeat (3) @(posedge clk);
      #1 arst_n = 1'b1;
      repeat (6) @(posedge clk);
      clear_corrupt();
      run("after_reset");

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
